// File: rtl/display_pkg.sv
// Shared constants, state type and helpers for the
// seven-segment display controller.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERROR = 7'b010_1010;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DECODE,
        COMMIT
    } state_t;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/SevenSegmentDisplay.sv
// Nibble to active-low segment decoder (bit 0 = a .. bit 6 = g).
// Nibble F yields the error pattern rather than a hex glyph.
module SevenSegmentDisplay
    import display_pkg::SEG_ERROR;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_ERROR;
        unique case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = SEG_ERROR;
        endcase
    end

endmodule

// File: rtl/seven_segment_controller.sv
// Binary to BCD (serial double-dabble) with a time-shared digit
// decoder, leading-zero blanking and atomic commit to the HEX pins.
module seven_segment_controller
    import display_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam logic [31:0] LIMIT = pow10(DIGITS) - 32'd1;

    state_t                state_q;
    state_t                state_nx;
    logic [WIDTH-1:0]      bin_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4:0]            cnt_q;
    logic                  ovf_nx_q;
    logic                  seen_nz_q;
    logic [7*DIGITS-1:0]   shadow_q;
    logic [2:0]            dig;
    logic [3:0]            nib;
    logic [3:0]            dec_in;
    logic [6:0]            dec_seg;
    logic                  blank;

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE:    if (load) state_nx = CONVERT;
            CONVERT: if (cnt_q == 5'(WIDTH - 1)) state_nx = DECODE;
            DECODE:  if (cnt_q == 5'(DIGITS - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // add-3 correction applied before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // most significant digit first during DECODE
    always_comb begin
        dig    = 3'(DIGITS - 1) - cnt_q[2:0];
        nib    = bcd_q[4*dig +: 4];
        dec_in = ovf_nx_q ? 4'hF : nib;
        blank  = !ovf_nx_q && (nib == 4'd0)
                 && !seen_nz_q && (dig != 3'd0);
    end

    SevenSegmentDisplay u_dec (
        .nibble (dec_in),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_nx_q  <= 1'b0;
            seen_nz_q <= 1'b0;
            shadow_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            hex_out   <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_nx;
            busy    <= (state_q != IDLE) && (state_q != COMMIT);
            done    <= (state_q == COMMIT);
            cnt_q   <= (state_nx != state_q) ? 5'd0 : cnt_q + 5'd1;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q     <= value_in;
                        bcd_q     <= '0;
                        ovf_nx_q  <= 32'(value_in) > LIMIT;
                        seen_nz_q <= 1'b0;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj[4*DIGITS-2:0], bin_q, 1'b0};
                end
                DECODE: begin
                    shadow_q[7*dig +: 7] <= blank ? SEG_BLANK : dec_seg;
                    if (nib != 4'd0) seen_nz_q <= 1'b1;
                end
                COMMIT: begin
                    hex_out  <= shadow_q;
                    overflow <= ovf_nx_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_controller.sv
// Directed and random checks of the seven-segment controller
// against an arithmetic decimal-display model.
module tb_seven_segment_controller;

    localparam int D  = 6;
    localparam int W  = 20;
    localparam int LAT = W + D + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    value_in;
    logic            load;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [7*D-1:0]  hex_out;

    int checks   = 0;
    int failures = 0;

    logic [7*D-1:0] prev_hex;
    logic           prev_ovf;

    always #5 clk = ~clk;

    seven_segment_controller #(.DIGITS(D), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex_out  (hex_out)
    );

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [7*D-1:0] model_hex(input int unsigned v);
        logic [7*D-1:0] h;
        bit nz;
        int unsigned p;
        int d;
        h  = '0;
        nz = 0;
        if (v > 999999) return {D{7'b0101010}};
        for (int k = D - 1; k >= 0; k--) begin
            p = 1;
            for (int i = 0; i < k; i++) p = p * 10;
            d = int'((v / p) % 10);
            if (d == 0 && !nz && k != 0) begin
                h[7*k +: 7] = 7'h7F;
            end else begin
                h[7*k +: 7] = glyph(d);
                nz = 1;
            end
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // load at edge t0, optionally poke ignored loads mid-run,
    // then verify outputs hold until done at t0+LAT
    task automatic convert(input int unsigned v, input bit poke);
        logic [7*D-1:0] exp;
        exp      = model_hex(v);
        value_in = W'(v);
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            if (poke && (c == 5 || c == 20)) begin
                load     = 1'b1;
                value_in = W'($urandom);
            end
            tick();
            load = 1'b0;
            if (c == 1) chk("busy_rise", 64'(busy), 64'd1);
            chk("hold", {20'(0), done, overflow, hex_out},
                {20'(0), 1'b0, prev_ovf, prev_hex});
        end
        tick();
        chk("done", 64'(done), 64'd1);
        chk("busy_fall", 64'(busy), 64'd0);
        chk("ovf", 64'(overflow), 64'(v > 999999));
        chk("hex", 64'(hex_out), 64'(exp));
        prev_hex = exp;
        prev_ovf = (v > 999999);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = '0;
        prev_hex = {D{7'h7F}};
        prev_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hex", 64'(hex_out), 64'({D{7'h7F}}));
        chk("rst_flags", {61'(0), busy, done, overflow}, 64'd0);

        convert(123456, 0);
        chk("d5_123456", 64'(hex_out[41:35]), 64'(7'b1111001));
        chk("d0_123456", 64'(hex_out[6:0]), 64'(7'b0000010));
        tick();
        chk("done_pulse", 64'(done), 64'd0);

        convert(42, 0);
        convert(0, 0);
        chk("zero_d0", 64'(hex_out[6:0]), 64'(7'b1000000));
        convert(1000000, 0);
        chk("ovf_pat", 64'(hex_out), 64'({D{7'b0101010}}));
        convert(7, 0);
        convert(999999, 0);
        convert(1048575, 0);

        // ignored loads, then back-to-back load in the done cycle
        convert(314159, 1);
        convert(100001, 0);
        convert(10, 1);

        // reset mid-conversion discards the result
        tick();
        value_in = W'(555555);
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hex", 64'(hex_out), 64'({D{7'h7F}}));
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done) seen++;
            end
            chk("no_done", 64'(seen), 64'd0);
        end
        prev_hex = {D{7'h7F}};
        prev_ovf = 1'b0;

        // load together with reset: reset wins
        value_in = W'(77);
        load     = 1'b1;
        reset    = 1'b1;
        tick();
        load  = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_wins", 64'(busy), 64'd0);

        for (int n = 0; n < 20; n++) begin
            int unsigned v;
            case (n % 3)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 999999);
                default: v = $urandom_range(0, (1 << W) - 1);
            endcase
            convert(v, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
